// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair.
// Both blocks take their default WIDTH/LIMIT from here, so they agree on
// the period without anyone having to keep two sets of numbers in sync.
package fib_pkg;

  localparam int FIB_WIDTH = 4;
  localparam int FIB_LIMIT = 13;

  typedef enum logic [1:0] {
    HUNT0 = 2'd0,
    HUNT1 = 2'd1,
    TRACK = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_term_model.sv
// Term model for the Fibonacci checker: keeps the previously accepted term,
// the term expected next and a phase counter, and advances them with the
// generator's recurrence.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_i        seed the model as if 0,0 were just accepted (expected = 1)
//   advance_i     the current expected term was accepted; step the model
//   limit_i       wrap threshold; a term >= limit_i ends a period
//   expected_o    registered term the next valid sample must equal
//   wrap_o        the current expected term is the last of a period
module fib_term_model
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] expected_o,
  output logic             wrap_o
);

  // The two most recent terms are last_q and, once accepted, exp_q itself,
  // so only one extra term register is needed.
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  // Phase only needs to distinguish 0, 1 and "2 or later"; it saturates at 2.
  logic [1:0]       phase_q, phase_d;
  logic [WIDTH:0]   sum;

  assign sum    = {1'b0, last_q} + {1'b0, exp_q};
  assign wrap_o = (exp_q >= limit_i);

  always_comb begin
    last_d  = last_q;
    exp_d   = exp_q;
    phase_d = phase_q;
    if (load_i) begin
      last_d  = '0;
      exp_d   = WIDTH'(1);
      phase_d = 2'd2;
    end else if (advance_i) begin
      last_d = exp_q;
      if (wrap_o) begin
        exp_d   = '0;
        phase_d = 2'd0;
      end else begin
        case (phase_q)
          2'd0: begin
            exp_d   = '0;
            phase_d = 2'd1;
          end
          2'd1: begin
            exp_d   = WIDTH'(1);
            phase_d = 2'd2;
          end
          default: begin
            // A carry means the recurrence left the representable range;
            // force 0 so anything but a restart is flagged.
            exp_d   = sum[WIDTH] ? '0 : sum[WIDTH-1:0];
            phase_d = 2'd2;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= '0;
      exp_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      last_q  <= last_d;
      exp_q   <= exp_d;
      phase_q <= phase_d;
    end
  end

  assign expected_o = exp_q;

endmodule

// File: rtl/fibonacci_checker.sv
// Receive-side checker for the Fibonacci generator's output stream.
// Hunts for the 0,0 restart pattern, then tracks the stream against its own
// term model, flagging mismatches and counting errors and verified periods.
//
// state | meaning
// ------+---------------------------------------------------------------
// HUNT0 | not locked, waiting for the first 0 of a restart
// HUNT1 | one 0 seen, a second 0 locks onto the stream
// TRACK | locked, every valid sample is compared against the model
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       qualifies in_data; nothing advances while low
//   in_data        sampled stream value
//   locked         stream currently matches the model
//   err_pulse      one-cycle pulse on a mismatch while locked
//   err_count      mismatches since reset, saturating
//   period_count   completed periods since reset, wrapping
//   expected       value the next valid sample must equal while locked
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int LIMIT = FIB_LIMIT,
  parameter int ERR_W = 8,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [PER_W-1:0] period_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  fib_state_e       state_q, state_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;

  logic             model_load;
  logic             model_adv;
  logic             model_wrap;
  logic [WIDTH-1:0] model_exp;

  fib_term_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (model_load),
    .advance_i  (model_adv),
    .limit_i    (LIMIT_V),
    .expected_o (model_exp),
    .wrap_o     (model_wrap)
  );

  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    per_cnt_d   = per_cnt_q;
    model_load  = 1'b0;
    model_adv   = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT0: begin
          if (in_data == '0) state_d = HUNT1;
        end
        HUNT1: begin
          if (in_data == '0) begin
            state_d    = TRACK;
            locked_d   = 1'b1;
            model_load = 1'b1;
          end else begin
            state_d = HUNT0;
          end
        end
        TRACK: begin
          if (in_data == model_exp) begin
            model_adv = 1'b1;
            if (model_wrap) per_cnt_d = per_cnt_q + 1'b1;
          end else begin
            // The offending sample is dropped, not reused as a first 0.
            err_pulse_d = 1'b1;
            locked_d    = 1'b0;
            state_d     = HUNT0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = HUNT0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      per_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      per_cnt_q   <= per_cnt_d;
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_cnt_q;
  assign period_count = per_cnt_q;
  assign expected     = model_exp;

endmodule

// File: tb/tb_fibonacci_checker.sv
module tb_fibonacci_checker;

  localparam int WIDTH = 4;
  localparam int LIMIT = 13;
  localparam int ERR_W = 2;
  localparam int PER_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [PER_W-1:0] period_count;
  logic [WIDTH-1:0] expected;

  always #5 clk = ~clk;

  fibonacci_checker #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT),
    .ERR_W (ERR_W),
    .PER_W (PER_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .period_count (period_count),
    .expected     (expected)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the period as a list of terms, and a position within it.
  int period[$];
  int r_locked, r_zero_seen, r_idx, r_err, r_per, r_pulse;
  int gen_idx;

  function automatic void build_period();
    int n;
    period = {};
    period.push_back(0);
    period.push_back(0);
    period.push_back(1);
    n = 3;
    while (period[n-1] < LIMIT) begin
      period.push_back(period[n-1] + period[n-2]);
      n++;
    end
  endfunction

  function automatic void ref_reset();
    r_locked = 0; r_zero_seen = 0; r_idx = 0;
    r_err = 0; r_per = 0; r_pulse = 0;
  endfunction

  function automatic void ref_sample(input bit v, input int d);
    r_pulse = 0;
    if (!v) return;
    if (r_locked != 0) begin
      if (d == period[r_idx]) begin
        if (d >= LIMIT) r_per = (r_per + 1) % (1 << PER_W);
        r_idx = (r_idx + 1) % period.size();
      end else begin
        r_pulse = 1;
        if (r_err < (1 << ERR_W) - 1) r_err++;
        r_locked = 0;
        r_zero_seen = 0;
      end
    end else if (d == 0) begin
      if (r_zero_seen != 0) begin
        r_locked = 1;
        r_idx = 2;
        r_zero_seen = 0;
      end else begin
        r_zero_seen = 1;
      end
    end else begin
      r_zero_seen = 0;
    end
  endfunction

  task automatic check_all();
    chk("locked", locked, r_locked);
    chk("err_pulse", err_pulse, r_pulse);
    chk("err_count", err_count, r_err);
    chk("period_count", period_count, r_per);
    if (r_locked != 0) chk("expected", expected, period[r_idx]);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input int d);
    in_valid = v;
    in_data  = WIDTH'(d);
    @(posedge clk);
    ref_sample(v, d);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic feed_clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, period[gen_idx]);
      gen_idx = (gen_idx + 1) % period.size();
    end
  endtask

  task automatic feed_until(input int idx);
    for (int i = 0; i < 40 && gen_idx != idx; i++) feed_clean(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_period_count"}, period_count, 0);
    chk({tag, "_expected"}, expected, 0);
  endtask

  initial begin
    int bad;
    build_period();
    ref_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    gen_idx  = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run of 20 samples from the period start.
    for (int i = 0; i < 20; i++) begin
      feed_clean(1);
      if (i == 1) chk("lock_after_00", locked, 1);
      if (i == 8) chk("period_after_13", period_count, 1);
    end
    chk("clean_err_count", err_count, 0);

    // Mismatch while expecting 5, then relock on 0,0.
    feed_until(6);
    chk("exp_is_5", expected, 5);
    step(1'b1, 6);
    chk("mis_pulse", err_pulse, 1);
    chk("mis_err_count", err_count, 1);
    chk("mis_unlocked", locked, 0);
    step(1'b0, 0);
    chk("mis_pulse_gone", err_pulse, 0);
    step(1'b1, 0);
    step(1'b1, 0);
    chk("relock", locked, 1);
    gen_idx = 2;

    // One period with an idle cycle after every sample.
    feed_until(0);
    for (int i = 0; i < period.size(); i++) begin
      feed_clean(1);
      step(1'b0, $urandom_range(0, 15));
    end

    // Asynchronous reset while expecting 5, applied between edges.
    feed_until(6);
    chk("pre_rst_exp", expected, 5);
    #2;
    rst_n = 1'b0;
    ref_reset();
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Garbage while hunting: lock only after the final 0,0, no errors counted.
    step(1'b1, 7);
    step(1'b1, 0);
    step(1'b1, 3);
    step(1'b1, 0);
    chk("garbage_unlocked", locked, 0);
    step(1'b1, 0);
    chk("garbage_lock", locked, 1);
    chk("garbage_err", err_count, 0);
    gen_idx = 2;

    // Five mismatches, relocking each time: counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      feed_clean($urandom_range(1, 9));
      bad = (period[gen_idx] + 1 + $urandom_range(0, 3)) % 16;
      step(1'b1, bad);
      chk("sat_pulse", err_pulse, 1);
      step(1'b1, 0);
      step(1'b1, 0);
      gen_idx = 2;
    end
    chk("err_saturated", err_count, 3);

    // Random traffic: gaps, corrupted samples, occasional bursts of zeros.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, $urandom_range(0, 15));
      end else if ($urandom_range(0, 24) == 0) begin
        step(1'b1, $urandom_range(0, 15));
        gen_idx = (gen_idx + 1) % period.size();
      end else if ($urandom_range(0, 99) == 0) begin
        step(1'b1, 0);
        step(1'b1, 0);
        gen_idx = 2;
      end else begin
        feed_clean(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
